// File: rtl/uart_frame_pkg.sv
// Shared state/error encodings and defaults for the uart_frame_rx command-packet receiver.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        HUNT,
        OPCODE,
        LEN,
        PAYLOAD,
        CSUM,
        EMIT
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_LEN     = 2'b01,
        ERR_CSUM    = 2'b10,
        ERR_TIMEOUT = 2'b11
    } err_code_t;

    localparam logic [7:0] SOF_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_frame_rx_if.sv
// Byte stream in from the uart receiver and tagged payload stream out to the host command logic.
interface uart_frame_rx_if;

    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    logic [7:0] out_data;
    logic [7:0] out_opcode;
    logic [7:0] out_len;
    logic       out_last;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_opcode, out_len, out_last, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_opcode, out_len, out_last, out_valid
    );

endinterface

// File: rtl/uart_frame_buf.sv
// Payload buffer: one synchronous write port, one combinational read port.
module uart_frame_buf #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en && (int'(wr_addr) < DEPTH)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Combinational read lets the first beat appear the cycle after the checksum byte.
    assign rd_data = (int'(rd_addr) < DEPTH) ? mem[rd_addr] : 8'h00;

endmodule

// File: rtl/uart_frame_rx.sv
// Frame hunter/validator behind the uart receiver; replays only good frames downstream.
// Optional inter-byte timeout is enabled by defining UART_FRAME_TIMEOUT_EN.
module uart_frame_rx
    import uart_frame_pkg::*;
#(
    parameter int         MAX_PAYLOAD    = 64,
    parameter logic [7:0] SOF            = SOF_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 12000
) (
    input  logic          clk,
    input  logic          reset,
    uart_frame_rx_if.slave bus,
    output logic          err,
    output logic [1:0]    err_code,
    output logic [7:0]    err_count
);

    localparam int         IDX_W   = $clog2(MAX_PAYLOAD + 1);
    localparam int         BUF_W   = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
    localparam logic [7:0] MAX_LEN = 8'(MAX_PAYLOAD);

    state_t          state;
    logic [IDX_W-1:0] idx;
    logic [7:0]      sum;
    logic [7:0]      frame_opcode;
    logic [7:0]      frame_len;

    logic            in_ready_q;
    logic            out_valid_q;
    logic            out_last_q;
    logic [7:0]      out_data_q;
    logic [7:0]      out_opcode_q;
    logic [7:0]      out_len_q;
    err_code_t       err_code_q;

    logic            accept;
    logic            wr_en;
    logic [BUF_W-1:0] wr_addr;
    logic [BUF_W-1:0] rd_addr;
    logic [7:0]      rd_data;
    logic            tmo_hit;
    logic            fail;
    err_code_t       fail_code;

    function automatic logic [7:0] add8(input logic [7:0] a, input logic [7:0] b);
        return a + b;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign accept  = bus.in_valid && in_ready_q;
    assign wr_en   = accept && (state == PAYLOAD);
    assign wr_addr = BUF_W'(idx);
    // During EMIT the read port looks one beat ahead so the next beat is ready on transfer.
    assign rd_addr = (state == EMIT) ? BUF_W'(idx + 1'b1) : '0;

    uart_frame_buf #(
        .DEPTH  (MAX_PAYLOAD),
        .ADDR_W (BUF_W)
    ) u_buf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (bus.in_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

`ifdef UART_FRAME_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             in_frame;

    assign in_frame = (state != HUNT) && (state != EMIT);

    always_ff @(posedge clk) begin
        if (!reset || !in_frame || accept) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign tmo_hit = in_frame && !accept && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        fail      = 1'b0;
        fail_code = ERR_NONE;
        if (accept && (state == LEN) && (bus.in_data > MAX_LEN)) begin
            fail      = 1'b1;
            fail_code = ERR_LEN;
        end else if (accept && (state == CSUM) && (add8(sum, bus.in_data) != 8'h00)) begin
            fail      = 1'b1;
            fail_code = ERR_CSUM;
        end else if (tmo_hit) begin
            fail      = 1'b1;
            fail_code = ERR_TIMEOUT;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= HUNT;
            idx          <= '0;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= 8'h00;
            out_opcode_q <= 8'h00;
            out_len_q    <= 8'h00;
            out_last_q   <= 1'b0;
            err          <= 1'b0;
            err_code_q   <= ERR_NONE;
            err_count    <= 8'h00;
        end else begin
            err <= 1'b0;
            unique case (state)
                HUNT: begin
                    in_ready_q <= 1'b1;
                    if (accept && (bus.in_data == SOF)) state <= OPCODE;
                end
                OPCODE: begin
                    if (accept) begin
                        frame_opcode <= bus.in_data;
                        sum          <= bus.in_data;
                        state        <= LEN;
                    end
                end
                LEN: begin
                    if (accept) begin
                        frame_len <= bus.in_data;
                        sum       <= add8(sum, bus.in_data);
                        idx       <= '0;
                        state     <= (bus.in_data == 8'h00) ? CSUM : PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (accept) begin
                        sum <= add8(sum, bus.in_data);
                        idx <= idx + 1'b1;
                        if (8'(idx) == frame_len - 8'd1) state <= CSUM;
                    end
                end
                CSUM: begin
                    if (accept && !fail) begin
                        state        <= EMIT;
                        in_ready_q   <= 1'b0;
                        idx          <= '0;
                        out_valid_q  <= 1'b1;
                        out_opcode_q <= frame_opcode;
                        out_len_q    <= frame_len;
                        out_data_q   <= (frame_len == 8'h00) ? 8'h00 : rd_data;
                        out_last_q   <= (frame_len <= 8'd1);
                    end
                end
                EMIT: begin
                    if (bus.out_ready) begin
                        if (out_last_q) begin
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            in_ready_q  <= 1'b1;
                            state       <= HUNT;
                        end else begin
                            idx        <= idx + 1'b1;
                            out_data_q <= rd_data;
                            out_last_q <= (8'(idx) + 8'd2 == frame_len);
                        end
                    end
                end
                default: state <= HUNT;
            endcase

            // A discarded frame overrides whatever the state decode chose.
            if (fail) begin
                state      <= HUNT;
                err        <= 1'b1;
                err_code_q <= fail_code;
                err_count  <= sat_inc8(err_count);
            end
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_opcode = out_opcode_q;
    assign bus.out_len    = out_len_q;
    assign bus.out_last   = out_last_q;
    assign err_code       = err_code_q;

endmodule
